// File: rtl/nl_stream_dma.sv
// -----------------------------------------------------------------------------
// nl_stream_dma
//
// Moves activation vectors between the activation SRAM and one nonlinear unit
// (softmax / layernorm / GELU).
//   * Read side: fetches two SRAM words per vector through port 0. The lower
//     address is the low half of the vector. It presents the 256-bit vector to
//     the unit on a valid/ready handshake.
//   * Write side: accepts results from the unit on a valid/ready handshake and
//     writes them back as two words through port 1, low half first.
// Both sides run concurrently. The transfer completes when the last result has
// been written.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   one-cycle start pulse (ignored while busy)
//   src_base, dst_base      first source / destination word address
//   num_vec                 number of 256-bit vectors to process
//   busy, done              status: busy level and one-cycle completion pulse
//   sram_*0                 SRAM port 0, used only for reads
//   sram_*1                 SRAM port 1, used only for writes
//   nl_in_valid/data/ready  vector stream toward the nonlinear unit
//   nl_out_valid/data/ready result stream from the nonlinear unit
// -----------------------------------------------------------------------------
module nl_stream_dma #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 128,
    parameter int CNT_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     src_base,
    input  logic [ADDR_W-1:0]     dst_base,
    input  logic [CNT_W-1:0]      num_vec,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           sram_wea0,
    output logic [ADDR_W-1:0]     sram_addr0,
    output logic [WORD_W-1:0]     sram_wdata0,
    input  logic [WORD_W-1:0]     sram_rdata0,
    output logic [15:0]           sram_wea1,
    output logic [ADDR_W-1:0]     sram_addr1,
    output logic [WORD_W-1:0]     sram_wdata1,
    output logic                  nl_in_valid,
    output logic [2*WORD_W-1:0]   nl_in_data,
    input  logic                  nl_in_ready,
    input  logic                  nl_out_valid,
    input  logic [2*WORD_W-1:0]   nl_out_data,
    output logic                  nl_out_ready
);

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_LO,
        RD_HI,
        RD_CAP,
        RD_SEND,
        RD_DONE
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WAIT,
        WR_LO,
        WR_HI
    } wr_state_t;

    rd_state_t          rd_state;
    wr_state_t          wr_state;
    logic [CNT_W-1:0]   num_reg;
    logic [CNT_W-1:0]   rd_cnt;
    logic [CNT_W-1:0]   wr_cnt;
    logic [ADDR_W-1:0]  dst_ptr;
    logic [WORD_W-1:0]  hi_word;
    logic               start_ok;
    logic               wr_last;

    // Port 0 never writes.
    assign sram_wea0   = 16'h0000;
    assign sram_wdata0 = '0;

    assign start_ok = start && !busy;

    // The final write beat of the transfer. It also retires the read side, so
    // both FSMs are idle by the time done is visible.
    assign wr_last = (wr_state == WR_HI) && ((wr_cnt + CNT_W'(1)) == num_reg);

    // -------------------------------------------------------------------------
    // Read FSM: RD_LO issues the low address. RD_HI issues the high address and
    // captures the low word, which returns one cycle after its address. RD_CAP
    // captures the high word. RD_SEND holds the vector until it is accepted.
    // sram_addr0 holds the high address through RD_CAP and RD_SEND, so the
    // next low address is simply +1.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state    <= RD_IDLE;
            rd_cnt      <= '0;
            sram_addr0  <= '0;
            nl_in_valid <= 1'b0;
            nl_in_data  <= '0;
        end else if (wr_last) begin
            rd_state    <= RD_IDLE;
            nl_in_valid <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (start_ok && (num_vec != '0)) begin
                        rd_state   <= RD_LO;
                        rd_cnt     <= '0;
                        sram_addr0 <= src_base;
                    end
                end
                RD_LO: begin
                    sram_addr0 <= sram_addr0 + ADDR_W'(1);
                    rd_state   <= RD_HI;
                end
                RD_HI: begin
                    // The low half may be overwritten here because valid is low.
                    nl_in_data[WORD_W-1:0] <= sram_rdata0;
                    rd_state               <= RD_CAP;
                end
                RD_CAP: begin
                    nl_in_data[2*WORD_W-1:WORD_W] <= sram_rdata0;
                    nl_in_valid                   <= 1'b1;
                    rd_state                      <= RD_SEND;
                end
                RD_SEND: begin
                    if (nl_in_ready) begin
                        nl_in_valid <= 1'b0;
                        rd_cnt      <= rd_cnt + CNT_W'(1);
                        if ((rd_cnt + CNT_W'(1)) < num_reg) begin
                            sram_addr0 <= sram_addr0 + ADDR_W'(1);
                            rd_state   <= RD_LO;
                        end else begin
                            rd_state <= RD_DONE;
                        end
                    end
                end
                RD_DONE: begin
                    // Wait for the write side to finish the transfer.
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Write FSM plus transfer control (busy/done, sampled parameters).
    // nl_out_ready is registered and is high only in WR_WAIT while results are
    // still owed. Extra result beats therefore never handshake.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state     <= WR_IDLE;
            wr_cnt       <= '0;
            num_reg      <= '0;
            dst_ptr      <= '0;
            hi_word      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            nl_out_ready <= 1'b0;
            sram_wea1    <= 16'h0000;
            sram_addr1   <= '0;
            sram_wdata1  <= '0;
        end else begin
            done <= 1'b0;
            // busy covers the done cycle and falls right after it.
            if (done) begin
                busy <= 1'b0;
            end
            case (wr_state)
                WR_IDLE: begin
                    if (start_ok) begin
                        busy    <= 1'b1;
                        num_reg <= num_vec;
                        dst_ptr <= dst_base;
                        wr_cnt  <= '0;
                        if (num_vec == '0) begin
                            done <= 1'b1;
                        end else begin
                            nl_out_ready <= 1'b1;
                            wr_state     <= WR_WAIT;
                        end
                    end
                end
                WR_WAIT: begin
                    if (nl_out_valid && nl_out_ready) begin
                        nl_out_ready <= 1'b0;
                        hi_word      <= nl_out_data[2*WORD_W-1:WORD_W];
                        sram_wea1    <= 16'hFFFF;
                        sram_addr1   <= dst_ptr;
                        sram_wdata1  <= nl_out_data[WORD_W-1:0];
                        wr_state     <= WR_LO;
                    end
                end
                WR_LO: begin
                    sram_addr1  <= dst_ptr + ADDR_W'(1);
                    sram_wdata1 <= hi_word;
                    wr_state    <= WR_HI;
                end
                WR_HI: begin
                    sram_wea1 <= 16'h0000;
                    dst_ptr   <= dst_ptr + ADDR_W'(2);
                    wr_cnt    <= wr_cnt + CNT_W'(1);
                    if (wr_last) begin
                        done     <= 1'b1;
                        wr_state <= WR_IDLE;
                    end else begin
                        nl_out_ready <= 1'b1;
                        wr_state     <= WR_WAIT;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nl_stream_dma.sv
// -----------------------------------------------------------------------------
// tb_nl_stream_dma: directed self-checking bench for nl_stream_dma.
// The bench models a two-port SRAM with a registered read. It also models a
// nonlinear unit that loops accepted vectors back after a short delay
// (optionally inverted), or that drives a constant result with valid forced high.
// -----------------------------------------------------------------------------
module tb_nl_stream_dma;
    localparam int ADDR_W = 16;
    localparam int WORD_W = 128;
    localparam int CNT_W  = 10;

    localparam logic [127:0] WA = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] WB = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] WC = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
    localparam logic [127:0] WD = 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF;
    localparam logic [127:0] KL = 128'hBEEF0000_11112222_33334444_55556666;
    localparam logic [127:0] KH = 128'hCAFE0000_77778888_9999AAAA_BBBBCCCC;
    localparam logic [255:0] CONST_K = {KH, KL};

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start;
    logic [ADDR_W-1:0]    src_base, dst_base;
    logic [CNT_W-1:0]     num_vec;
    logic                 busy, done;
    logic [15:0]          sram_wea0, sram_wea1;
    logic [ADDR_W-1:0]    sram_addr0, sram_addr1;
    logic [WORD_W-1:0]    sram_wdata0, sram_wdata1, sram_rdata0;
    logic                 nl_in_valid, nl_in_ready, nl_out_valid, nl_out_ready;
    logic [255:0]         nl_in_data, nl_out_data;

    always #5 clk = ~clk;

    nl_stream_dma #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_base(src_base), .dst_base(dst_base), .num_vec(num_vec),
        .busy(busy), .done(done),
        .sram_wea0(sram_wea0), .sram_addr0(sram_addr0), .sram_wdata0(sram_wdata0),
        .sram_rdata0(sram_rdata0),
        .sram_wea1(sram_wea1), .sram_addr1(sram_addr1), .sram_wdata1(sram_wdata1),
        .nl_in_valid(nl_in_valid), .nl_in_data(nl_in_data), .nl_in_ready(nl_in_ready),
        .nl_out_valid(nl_out_valid), .nl_out_data(nl_out_data), .nl_out_ready(nl_out_ready)
    );

    // ---------------- SRAM model (bench preload shares port 1 timing) -------
    logic [WORD_W-1:0] mem [0:1023];
    logic              poke_en;
    logic [9:0]        poke_addr;
    logic [WORD_W-1:0] poke_data;

    always @(posedge clk) begin
        sram_rdata0 <= mem[sram_addr0[9:0]];
        if (poke_en)
            mem[poke_addr] <= poke_data;
        else if (sram_wea1 == 16'hFFFF)
            mem[sram_addr1[9:0]] <= sram_wdata1;
    end

    // ---------------- nonlinear unit model ----------------------------------
    logic         in_ready, loop_en, invert, force_valid;
    logic         u_from_q;
    logic [255:0] u_data;
    logic [255:0] q_data[$];
    int           q_time[$];
    int           cyc = 0;

    assign nl_in_ready  = in_ready;
    assign nl_out_valid = u_from_q | force_valid;
    assign nl_out_data  = u_from_q ? u_data : CONST_K;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data.delete();
            q_time.delete();
            u_from_q <= 1'b0;
            u_data   <= '0;
        end else begin
            cyc++;
            if (u_from_q && nl_out_ready) begin
                void'(q_data.pop_front());
                void'(q_time.pop_front());
            end
            if (loop_en && nl_in_valid && nl_in_ready) begin
                q_data.push_back(invert ? ~nl_in_data : nl_in_data);
                q_time.push_back(cyc + 3);
            end
            if (q_data.size() > 0 && q_time[0] <= cyc) begin
                u_from_q <= 1'b1;
                u_data   <= q_data[0];
            end else begin
                u_from_q <= 1'b0;
            end
        end
    end

    // ---------------- event monitors ----------------------------------------
    int           in_hs = 0, out_hs = 0, done_cnt = 0, wea_nz = 0, inv_cnt = 0;
    int           rdy_in_wr = 0, stall_viol = 0;
    logic         prev_stall = 1'b0;
    logic [255:0] prev_data;
    logic [15:0]  prev_addr;

    always @(posedge clk) begin
        if (nl_in_valid && nl_in_ready) in_hs++;
        if (nl_out_valid && nl_out_ready) out_hs++;
        if (done) done_cnt++;
        if (sram_wea1 != 16'h0000) wea_nz++;
        if (nl_in_valid) inv_cnt++;
        if (nl_out_ready && sram_wea1 != 16'h0000) rdy_in_wr++;
        if (prev_stall && (!nl_in_valid || nl_in_data !== prev_data || sram_addr0 !== prev_addr))
            stall_viol++;
        prev_stall = nl_in_valid && !nl_in_ready;
        prev_data  = nl_in_data;
        prev_addr  = sram_addr0;
    end

    // ---------------- helpers -----------------------------------------------
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int i);
        return {96'hA5A55A5A_0F0FF0F0_12345678, 32'(i)};
    endfunction

    task automatic poke(input int a, input logic [127:0] v);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a[9:0];
        poke_data = v;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Returns at the negedge of cycle t+1 after the accepting edge t.
    task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [9:0] n);
        @(negedge clk);
        src_base = s;
        dst_base = d;
        num_vec  = n;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle (ok=1) or after max cycles.
    task automatic wait_done(input int max, output int busy_low, output bit ok);
        busy_low = 0;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (!busy) busy_low++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence -------------------------------------
    initial begin
        int bl;
        bit ok;
        int b_in, b_out, b_done, b_wea, b_inv, b_rdy, b_stall;

        start = 1'b0; src_base = '0; dst_base = '0; num_vec = '0;
        in_ready = 1'b1; loop_en = 1'b1; invert = 1'b0; force_valid = 1'b0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_valid", nl_in_valid, 0);
        chk("rst_out_ready", nl_out_ready, 0);
        chk("rst_wea1", sram_wea1, 0);
        chk("rst_wea0", sram_wea0, 0);
        chk("rst_wdata0", sram_wdata0, 0);
        rst_n = 1'b1;

        // Test 1: single vector, latency and half ordering
        poke(0, WA); poke(1, WB); poke(256, '0); poke(257, '0);
        invert = 1'b1;
        b_done = done_cnt;
        do_start(16'd0, 16'd256, 10'd1);
        chk("t1_busy_t1", busy, 1);
        chk("t1_addr0_t1", sram_addr0, 0);
        @(negedge clk);
        chk("t1_addr0_t2", sram_addr0, 1);
        @(negedge clk);
        chk("t1_valid_t3", nl_in_valid, 0);
        @(negedge clk);
        chk("t1_valid_t4", nl_in_valid, 1);
        chk("t1_data_t4", nl_in_data, {WB, WA});
        wait_done(100, bl, ok);
        chk("t1_done_seen", ok, 1);
        repeat (3) @(negedge clk);
        chk("t1_mem256", mem[256], WC);
        chk("t1_mem257", mem[257], WD);
        chk("t1_done_once", done_cnt - b_done, 1);
        chk("t1_busy_after", busy, 0);
        chk("t1_wdata0", sram_wdata0, 0);
        invert = 1'b0;

        // Test 2: 28 vectors through a 3-cycle loopback
        for (int i = 0; i < 56; i++) poke(i, pat(i));
        for (int i = 256; i < 312; i++) poke(i, '0);
        b_in = in_hs; b_out = out_hs; b_done = done_cnt;
        do_start(16'd0, 16'd256, 10'd28);
        wait_done(2000, bl, ok);
        chk("t2_done_seen", ok, 1);
        chk("t2_busy_gaps", bl, 0);
        repeat (3) @(negedge clk);
        chk("t2_in_hs", in_hs - b_in, 28);
        chk("t2_out_hs", out_hs - b_out, 28);
        chk("t2_done_once", done_cnt - b_done, 1);
        for (int i = 0; i < 56; i++) chk($sformatf("t2_mem%0d", 256 + i), mem[256 + i], pat(i));

        // Test 3: in-side backpressure for 7 cycles
        for (int i = 512; i < 516; i++) poke(i, '0);
        in_ready = 1'b0;
        b_in = in_hs; b_stall = stall_viol;
        do_start(16'd0, 16'd512, 10'd2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (nl_in_valid) break;
        end
        chk("t3_valid_seen", nl_in_valid, 1);
        repeat (7) @(negedge clk);
        chk("t3_valid_held", nl_in_valid, 1);
        chk("t3_data_held", nl_in_data, {pat(1), pat(0)});
        chk("t3_addr_held", sram_addr0, 1);
        in_ready = 1'b1;
        wait_done(500, bl, ok);
        chk("t3_done_seen", ok, 1);
        repeat (2) @(negedge clk);
        chk("t3_stall_viol", stall_viol - b_stall, 0);
        chk("t3_in_hs", in_hs - b_in, 2);
        for (int i = 0; i < 4; i++) chk($sformatf("t3_mem%0d", 512 + i), mem[512 + i], pat(i));

        // Test 4: unit holds out_valid high; only num_vec results accepted
        for (int i = 600; i < 605; i++) poke(i, '0);
        loop_en = 1'b0;
        force_valid = 1'b1;
        b_out = out_hs; b_rdy = rdy_in_wr;
        do_start(16'd0, 16'd600, 10'd2);
        wait_done(200, bl, ok);
        chk("t4_done_seen", ok, 1);
        repeat (5) @(negedge clk);
        chk("t4_out_hs", out_hs - b_out, 2);
        chk("t4_ready_in_write", rdy_in_wr - b_rdy, 0);
        chk("t4_ready_after", nl_out_ready, 0);
        chk("t4_in_valid_after", nl_in_valid, 0);
        chk("t4_mem600", mem[600], KL);
        chk("t4_mem601", mem[601], KH);
        chk("t4_mem602", mem[602], KL);
        chk("t4_mem603", mem[603], KH);
        chk("t4_mem604", mem[604], 0);
        force_valid = 1'b0;
        loop_en = 1'b1;

        // Test 5a: num_vec = 0
        b_wea = wea_nz; b_inv = inv_cnt; b_done = done_cnt;
        do_start(16'd0, 16'd800, 10'd0);
        chk("t5_done_t1", done, 1);
        chk("t5_busy_t1", busy, 1);
        @(negedge clk);
        chk("t5_done_t2", done, 0);
        chk("t5_busy_t2", busy, 0);
        repeat (3) @(negedge clk);
        chk("t5_no_write", wea_nz - b_wea, 0);
        chk("t5_no_in_valid", inv_cnt - b_inv, 0);
        chk("t5_done_once", done_cnt - b_done, 1);

        // Test 5b: starts during busy and on the done cycle are ignored
        poke(820, '0); poke(821, '0);
        b_in = in_hs; b_out = out_hs; b_done = done_cnt;
        do_start(16'd0, 16'd820, 10'd1);
        @(negedge clk);
        src_base = 16'd100; dst_base = 16'd900; num_vec = 10'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, bl, ok);
        chk("t5_done_seen", ok, 1);
        start = 1'b1; num_vec = 10'd1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_start_on_done_ignored", busy, 0);
        repeat (5) @(negedge clk);
        chk("t5_in_hs", in_hs - b_in, 1);
        chk("t5_out_hs", out_hs - b_out, 1);
        chk("t5_done_count", done_cnt - b_done, 1);
        chk("t5_mem820", mem[820], pat(0));
        chk("t5_mem821", mem[821], pat(1));

        // Test 6: asynchronous reset mid-transfer, then a fresh transfer
        b_in = in_hs; b_done = done_cnt;
        do_start(16'd0, 16'd700, 10'd8);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_hs - b_in >= 3) break;
        end
        chk("t6_three_vectors", (in_hs - b_in >= 3) ? 1 : 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_in_valid", nl_in_valid, 0);
        chk("t6_in_data", nl_in_data, 0);
        chk("t6_out_ready", nl_out_ready, 0);
        chk("t6_wea1", sram_wea1, 0);
        chk("t6_addr0", sram_addr0, 0);
        chk("t6_addr1", sram_addr1, 0);
        chk("t6_wdata1", sram_wdata1, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_no_done", done_cnt - b_done, 0);
        for (int i = 960; i < 964; i++) poke(i, '0);
        b_done = done_cnt;
        do_start(16'd0, 16'd960, 10'd2);
        wait_done(300, bl, ok);
        chk("t6_restart_done", ok, 1);
        repeat (2) @(negedge clk);
        chk("t6_restart_done_once", done_cnt - b_done, 1);
        for (int i = 0; i < 4; i++) chk($sformatf("t6_mem%0d", 960 + i), mem[960 + i], pat(i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nl_stream_dma.md
Name: nl_stream_dma

Overview:
- Streams activation vectors from the activation SRAM into a nonlinear unit (softmax, layernorm or GELU) over its valid/ready input handshake.
- Collects the unit's results over its output handshake and writes them back to the activation SRAM.
- Acts as the initiator/consumer end of the nonlinear-unit stream protocol inside bert_encoder.
- One instance serves one unit; the top-level selects the unit.

Parameters:
- ADDR_W, 16, SRAM word address width.
- WORD_W, 128, SRAM word width; a stream vector is 2*WORD_W = 256 bits.
- CNT_W, 10, width of the vector count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begin a transfer; ignored while busy=1.
- src_base  in  ADDR_W  first source word address; sampled on start.
- dst_base  in  ADDR_W  first destination word address; sampled on start.
- num_vec  in  CNT_W  number of 256-bit vectors; sampled on start.
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse when the last result word has been written.
- sram_wea0  out  16  read port byte-write enables; always 16'h0000.
- sram_addr0  out  ADDR_W  read address.
- sram_wdata0  out  WORD_W  always 0.
- sram_rdata0  in  WORD_W  read data; valid 1 cycle after the address.
- sram_wea1  out  16  write port byte enables; 16'hFFFF on a write cycle, else 0.
- sram_addr1  out  ADDR_W  write address.
- sram_wdata1  out  WORD_W  write data.
- nl_in_valid  out  1  vector valid toward the unit.
- nl_in_data  out  256  vector; [127:0]=low word, [255:128]=high word.
- nl_in_ready  in  1  unit accepts the vector.
- nl_out_valid  in  1  unit result valid.
- nl_out_data  in  256  result vector.
- nl_out_ready  out  1  DMA accepts the result.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs 0; both FSMs go to IDLE; counters clear.
  - Asserting reset mid-transfer aborts the transfer; no partial done pulse.
- Vector layout:
  - Vector i is read from words src_base+2i (low half) and src_base+2i+1 (high half).
  - Result i is written to dst_base+2i (low half), then dst_base+2i+1 (high half).
  - Addresses wrap modulo 2^ADDR_W.
- Read FSM states: IDLE -> RD_LO -> RD_HI -> CAP -> SEND -> (RD_LO | RD_DONE).
  - RD_LO drives sram_addr0 = lo address.
  - RD_HI drives sram_addr0 = hi address and captures the low word.
  - CAP captures the high word.
  - SEND holds nl_in_valid=1 with nl_in_data stable until nl_in_ready=1.
  - The vector transfers on the cycle where valid and ready are both high. The FSM then goes to RD_LO if vectors remain, else to RD_DONE.
- Read latency: an accepted start at edge t gives sram_addr0=src_base in cycle t+1 and nl_in_valid=1 from cycle t+4. Steady-state throughput is one vector per 4 cycles with ready tied high.
- Write FSM states: IDLE -> WAIT -> WR_LO -> WR_HI -> WAIT.
  - nl_out_ready=1 only in WAIT while results received < num_vec.
  - On an out handshake, nl_out_data is latched and the FSM goes to WR_LO (sram_wea1=FFFF, low word), then WR_HI (high word).
  - Result beats beyond num_vec are never accepted; nl_out_ready stays 0.
- The read and write FSMs run concurrently. Reads use port 0 only and writes use port 1 only, so there is no port conflict.
- Completion:
  - done pulses in the cycle after the WR_HI of result num_vec-1, and busy drops after that cycle.
  - Both FSMs return to IDLE.
- num_vec=0: done=1 in cycle t+1. No SRAM access and no nl_in_valid.
- A start arriving in the same cycle as done is ignored. A new start is accepted the cycle after done.
- The high word of nl_in_data comes from the later SRAM word, and the same ordering applies to writes.

Test Plan:
1. src_base=0, dst_base=256, num_vec=1, low word A, high word B, nl_in_ready=1 -> nl_in_valid rises at t+4 with data {B,A}. The unit returns {D,C}; RAM[256]=C, RAM[257]=D, then one done pulse.
2. num_vec=28, unit modelled as a 3-cycle delay loopback -> RAM[256..311] equals RAM[0..55], exactly 28 in-handshakes, done once, busy high throughout.
3. nl_in_ready held 0 for 7 cycles while valid -> nl_in_valid and nl_in_data stay stable, no new sram_addr0 sequence starts, and the transfer completes correctly after ready rises.
4. Unit asserts nl_out_valid continuously with num_vec=2 -> exactly 2 results accepted; nl_out_ready=0 during WR_LO/WR_HI and after the second result.
5. num_vec=0 -> done at t+1, sram_wea1 never nonzero, nl_in_valid never 1. A start pulse during busy in another run is ignored (counts unchanged).
6. rst_n pulsed low mid-transfer (after 3 vectors) -> all outputs 0 asynchronously and no done. A fresh start then completes normally.
